// File: rtl/nco_poly.sv
// Polyphonic time-multiplexed NCO: one prescaler tick walks every voice through
// a step-ROM fetch, phase accumulate and waveform lookup, then publishes the mix.
module nco_poly #(
  parameter int VOICES  = 4,
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8,
  parameter int DIV     = 2268,
  parameter int NOTE_W  = 7
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [VOICES*NOTE_W-1:0]           NOTE_NUM,
  input  logic [VOICES-1:0]                  GATE,
  input  logic [1:0]                         MODE,
  output logic [NOTE_W-1:0]                  STEP_ADDR,
  output logic                               STEP_EN,
  input  logic [PHASE_W-1:0]                 STEP_DATA,
  output logic [OUT_W+$clog2(VOICES)-1:0]    MIX,
  output logic                               VALID,
  output logic                               OVERRUN
);

  localparam int MIX_W = OUT_W + $clog2(VOICES);
  localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ACC   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [VW-1:0] LAST_V  = VW'(VOICES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]      cnt;
  logic               tick;
  logic [1:0]         state;
  logic [VW-1:0]      v;
  logic [MIX_W-1:0]   acc;
  logic [PHASE_W-1:0] phase [VOICES];

  logic [PHASE_W-1:0] phase_nxt;
  logic [OUT_W-1:0]   samp;
  logic [MIX_W-1:0]   acc_nxt;

  function automatic logic [OUT_W-1:0] wave(input logic [1:0] m, input logic [OUT_W-1:0] p);
    logic [OUT_W-1:0] ramp;
    ramp = {p[OUT_W-2:0], 1'b0};
    case (m)
      2'd0:    wave = p;
      2'd1:    wave = p[OUT_W-1] ? '0 : '1;
      2'd2:    wave = p[OUT_W-1] ? ~ramp : ramp;
      default: wave = (p[OUT_W-1 -: 2] == 2'b00) ? '1 : '0;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

  // ROM data arrives in ACC, one cycle after the FETCH that addressed it
  always_comb begin
    phase_nxt = phase[v] + STEP_DATA;
    samp      = wave(MODE, phase_nxt[PHASE_W-1 -: OUT_W]);
    acc_nxt   = GATE[v] ? (acc + MIX_W'(samp)) : acc;
  end

  assign STEP_EN   = (state == FETCH);
  assign STEP_ADDR = (state == FETCH) ? NOTE_NUM[v*NOTE_W +: NOTE_W] : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      v       <= '0;
      acc     <= '0;
      MIX     <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
      for (int i = 0; i < VOICES; i++) phase[i] <= '0;
    end else begin
      VALID <= 1'b0;
      if (tick && state != IDLE) OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            v     <= '0;
            acc   <= '0;
            state <= FETCH;
          end
        end
        FETCH: state <= ACC;
        ACC: begin
          phase[v] <= GATE[v] ? phase_nxt : '0;
          acc      <= acc_nxt;
          // MIX and VALID land together so the DONE cycle presents the new sum
          if (v == LAST_V) begin
            MIX   <= acc_nxt;
            VALID <= 1'b1;
            state <= DONE;
          end else begin
            v     <= v + VW'(1);
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nco_poly.md
Name: nco_poly

Overview:
- Polyphonic, time-multiplexed numerically controlled oscillator.
- An internal prescaler generates a sample tick. On each tick the block walks every voice in turn:
  - fetches that voice's phase step from an external step-size ROM, addressed by the voice's note number;
  - advances the voice's phase accumulator;
  - converts the phase to the selected waveform;
  - adds the result into a mix.
- Sits between the note/gate control logic and the audio output path.
- Generalises the single-voice, fixed-rate oscillator to N voices, a programmable sample rate and four waveforms.

Parameters:
- VOICES, 4, number of voices (1..16).
- PHASE_W, 24, phase accumulator width per voice.
- OUT_W, 8, per-voice waveform sample width (unsigned).
- DIV, 2268, prescaler modulo in CLK cycles per sample tick. Must satisfy DIV >= 2*VOICES+2.
- NOTE_W, 7, note number width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- NOTE_NUM  in  VOICES*NOTE_W  packed note numbers; voice v occupies bits [v*NOTE_W +: NOTE_W].
- GATE  in  VOICES  per-voice enable.
- MODE  in  2  waveform select, shared by all voices: 0 saw, 1 square, 2 triangle, 3 pulse 25%.
- STEP_ADDR  out  NOTE_W  address to the step-size ROM.
- STEP_EN  out  1  ROM read enable.
- STEP_DATA  in  PHASE_W  ROM data; valid exactly 1 cycle after STEP_EN.
- MIX  out  OUT_W+clog2(VOICES)  summed sample, registered.
- VALID  out  1  1-cycle pulse when MIX updates.
- OVERRUN  out  1  sticky error flag.

Behaviour:
- Reset (RST_N low, async):
  - prescaler = 0; all phases = 0; FSM = IDLE.
  - MIX = 0, VALID = 0, OVERRUN = 0, STEP_EN = 0, STEP_ADDR = 0.
  - Reset asserted mid-sweep aborts the sweep. No VALID is produced for it.
- Prescaler:
  - Counts 0..DIV-1 continuously and wraps to 0.
  - TICK is high for 1 cycle when count == DIV-1.
- FSM states: IDLE, FETCH, ACC, DONE. Voice index v and accumulator acc are internal.
  - IDLE: on TICK, set v=0, acc=0, go to FETCH.
  - FETCH: STEP_EN=1, STEP_ADDR=NOTE_NUM[v]. NOTE_NUM is sampled in this cycle. Go to ACC.
  - ACC: STEP_EN=0.
    - If GATE[v]: phase[v] <= phase[v]+STEP_DATA, modulo 2^PHASE_W; acc += wave(new phase).
    - Else: phase[v] <= 0; acc unchanged.
    - If v==VOICES-1 go to DONE; else v++ and go to FETCH.
  - DONE: MIX <= acc, VALID=1 for this cycle, go to IDLE.
- Timing:
  - Latency from TICK to VALID = 2*VOICES+1 cycles.
  - Exactly one VALID per TICK.
- Waveform: let p = phase[PHASE_W-1 -: OUT_W] (new phase).
  - saw = p.
  - square = p[MSB] ? 0 : all-ones.
  - triangle = p[MSB] ? ~{p[OUT_W-2:0],0} : {p[OUT_W-2:0],0}.
  - pulse = (p[MSB:MSB-1]==0) ? all-ones : 0.
- MODE is sampled per voice in ACC. A change mid-sweep affects only the remaining voices.
- Arithmetic:
  - acc and MIX are OUT_W+clog2(VOICES) bits wide; no saturation is needed.
  - Phase wrap-around is natural modulo.
- Overrun:
  - A TICK arriving while FSM != IDLE is ignored and sets OVERRUN=1.
  - OVERRUN clears only on reset. This is unreachable when the DIV constraint holds; covered with a bench override.
- Gate edges:
  - A rising GATE starts the voice from phase 0.
  - A falling GATE zeroes the phase at that voice's next ACC.

Test Plan:
- Reset:
  - Stimulus: assert RST_N low mid-sweep (during ACC of voice 2).
  - Required: MIX=0, VALID=0, OVERRUN=0, STEP_EN=0 immediately (asynchronously); after release, the first VALID comes 2*VOICES+1 cycles after the next TICK.
- Saw, single voice:
  - Stimulus: VOICES=4, DIV=16, bench ROM returns 0x010000 for any address, GATE=0001, MODE=0.
  - Required: MIX = 1, 2, 3, ... on successive VALIDs; after 256 ticks MIX wraps to 0.
- Handshake:
  - Stimulus: NOTE_NUM = {7'd60, 7'd64, 7'd67, 7'd72}, all gates on.
  - Required: STEP_ADDR sequence per sweep = 72, 67, 64, 60 (voice 0 first); STEP_EN high exactly 4 cycles per sweep, 2 cycles apart.
- Waveforms:
  - Stimulus: ROM = 0x400000, single voice, step through MODE 1, 2 and 3.
  - Required (MSB of p across ticks = 0x40, 0x80, 0xC0, 0x00):
    - square: 0xFF, 0x00, 0x00, 0xFF;
    - triangle: 0x80, 0xFF, 0x7F, 0x00;
    - pulse: 0x00, 0x00, 0x00, 0xFF.
- Mix and gate:
  - Stimulus: 4 voices, ROM = 0xFF0000, MODE=1 (square).
  - Required: first sweep MIX = 0 (p=0xFF, MSB set); drop GATE[0] → that voice's phase goes to 0 and its contribution is removed.
- Overrun:
  - Stimulus: DIV=6 with VOICES=4.
  - Required: OVERRUN rises on the first TICK landing mid-sweep; VALID count = number of accepted ticks; flag stays set until RST_N goes low.
